// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and issues reads to a 1-cycle-latency synchronous instruction memory.
// A one-entry skid register catches the in-flight response during a decode stall,
// so no fetched word is lost or fetched twice. A flush redirects the PC and squashes
// the stage.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid
);

    logic        run_q,        run_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] f_pc_q,       f_pc_d;
    logic        f_vld_q,      f_vld_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q,    skid_pc_d;
    logic        skid_vld_q,   skid_vld_d;
    logic [31:0] id_instr_q,   id_instr_d;
    logic [31:0] id_pc_q,      id_pc_d;
    logic [31:0] id_pc4_q,     id_pc4_d;
    logic        id_valid_q,   id_valid_d;

    // Requests stop whenever decode stalls or a redirect is in progress.
    assign imem_req    = run_q & ~stall & ~flush;
    assign imem_addr   = pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc4_q;
    assign id_valid    = id_valid_q;

    // Next-state logic: PC/issue tracking, skid capture and ID register update.
    always_comb begin
        run_d        = 1'b1;
        pc_d         = pc_q;
        f_pc_d       = f_pc_q;
        f_vld_d      = 1'b0;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_vld_d   = skid_vld_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        id_valid_d   = id_valid_q;

        if (flush) begin
            // The in-flight response and any skid entry belong to the wrong path.
            pc_d       = {redirect_pc[31:2], 2'b00};
            skid_vld_d = 1'b0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else begin
            if (imem_req) begin
                pc_d    = pc_q + 32'd4;
                f_pc_d  = pc_q;
                f_vld_d = 1'b1;
            end

            if (stall) begin
                // Park the arriving word; no request was issued, so the skid
                // entry cannot be overwritten until the stall releases.
                if (f_vld_q) begin
                    skid_instr_d = imem_rdata;
                    skid_pc_d    = f_pc_q;
                    skid_vld_d   = 1'b1;
                end
            end else if (skid_vld_q) begin
                id_instr_d = skid_instr_q;
                id_pc_d    = skid_pc_q;
                id_pc4_d   = skid_pc_q + 32'd4;
                id_valid_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (f_vld_q) begin
                id_instr_d = imem_rdata;
                id_pc_d    = f_pc_q;
                id_pc4_d   = f_pc_q + 32'd4;
                id_valid_d = 1'b1;
            end else begin
                // Bubble: keep the last PC so id_pc stays meaningful.
                id_instr_d = NOP_INSTR;
                id_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            pc_q         <= RESET_PC;
            f_pc_q       <= 32'h0;
            f_vld_q      <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
            skid_vld_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= 32'h0;
            id_pc4_q     <= 32'd4;
            id_valid_q   <= 1'b0;
        end else begin
            run_q        <= run_d;
            pc_q         <= pc_d;
            f_pc_q       <= f_pc_d;
            f_vld_q      <= f_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_vld_q   <= skid_vld_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            id_valid_q   <= id_valid_d;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: directed timing scenarios followed by random
// stall/flush traffic checked against a program-order delivery model.
module tb_if_id_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] id_instr, id_pc, id_pc_plus4;
    logic        id_valid;

    // Second instance with a reset vector near the top of the address space.
    logic        rst2_n, stall2, flush2;
    logic [31:0] redirect2_pc;
    logic        imem2_req;
    logic [31:0] imem2_addr, imem2_rdata;
    logic [31:0] id2_instr, id2_pc, id2_pc_plus4;
    logic        id2_valid;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: fetch address expected next, PC expected next in ID.
    logic        run_seen;
    logic [31:0] exp_fetch, exp_del;

    always #5 clk = ~clk;

    if_id_fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
    );

    if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst2_n), .stall(stall2), .flush(flush2),
        .redirect_pc(redirect2_pc), .imem_req(imem2_req), .imem_addr(imem2_addr),
        .imem_rdata(imem2_rdata), .id_instr(id2_instr), .id_pc(id2_pc),
        .id_pc_plus4(id2_pc_plus4), .id_valid(id2_valid)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h0010_0093 + (a >> 2);
    endfunction

    // Instruction memories: data one cycle after a request, X otherwise.
    always @(posedge clk) imem_rdata  <= imem_req  ? memf(imem_addr)  : 32'hxxxx_xxxx;
    always @(posedge clk) imem2_rdata <= imem2_req ? memf(imem2_addr) : 32'hxxxx_xxxx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_req",   {31'b0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_instr", id_instr, NOP);
        chk("rst_pc",    id_pc, 32'h0);
        chk("rst_pc4",   id_pc_plus4, 32'd4);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
    endtask

    // Assert reset off-edge, check it takes effect immediately, release off-edge.
    task automatic do_reset();
        stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
        rst_n = 1'b0;
        #1 chk_reset();
        repeat (3) @(posedge clk);
        #1 chk_reset();
        rst_n     = 1'b1;
        run_seen  = 1'b0;
        exp_fetch = 32'h0;
        exp_del   = 32'h0;
    endtask

    // One clock cycle with the given controls, checked against the model.
    task automatic cyc(input logic st, input logic fl, input logic [31:0] rpc);
        logic [31:0] p_instr, p_pc, p_pc4;
        logic        p_v, exp_req;
        stall = st; flush = fl; redirect_pc = rpc;
        #1;
        exp_req = run_seen & ~st & ~fl;
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, exp_fetch);
        p_instr = id_instr; p_pc = id_pc; p_pc4 = id_pc_plus4; p_v = id_valid;
        @(posedge clk);
        #1;
        run_seen = 1'b1;
        if (fl) begin
            exp_fetch = {rpc[31:2], 2'b00};
            exp_del   = exp_fetch;
            chk("flush_valid", {31'b0, id_valid}, 32'd0);
            chk("flush_instr", id_instr, NOP);
        end else begin
            if (exp_req) exp_fetch = exp_fetch + 32'd4;
            if (st) begin
                chk("stall_instr", id_instr, p_instr);
                chk("stall_pc",    id_pc, p_pc);
                chk("stall_pc4",   id_pc_plus4, p_pc4);
                chk("stall_valid", {31'b0, id_valid}, {31'b0, p_v});
            end else if (id_valid) begin
                chk("deliver_pc",    id_pc, exp_del);
                chk("deliver_instr", id_instr, memf(exp_del));
                chk("deliver_pc4",   id_pc_plus4, exp_del + 32'd4);
                exp_del = exp_del + 32'd4;
            end else begin
                chk("bubble_instr", id_instr, NOP);
                chk("bubble_pc",    id_pc, p_pc);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
        rst2_n = 1'b0; stall2 = 1'b0; flush2 = 1'b0; redirect2_pc = 32'h0;
        run_seen = 1'b0; exp_fetch = 32'h0; exp_del = 32'h0;

        // T1: reset and start-up latency
        @(posedge clk);
        #1 do_reset();
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t1_not_yet_valid", {31'b0, id_valid}, 32'd0);
        cyc(0, 0, 0);
        chk("t1_first_valid", {31'b0, id_valid}, 32'd1);
        chk("t1_first_pc", id_pc, 32'h0);
        chk("t1_first_pc4", id_pc_plus4, 32'd4);

        // T2: streaming, one instruction per cycle
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0);
            chk("t2_stream_valid", {31'b0, id_valid}, 32'd1);
            chk("t2_stream_instr", id_instr, 32'h0010_0093 + i);
        end

        // T3: stall with 0x10 in flight
        chk("t3_pre_pc", id_pc, 32'h0C);
        repeat (3) begin
            cyc(1, 0, 0);
            chk("t3_hold_pc", id_pc, 32'h0C);
        end
        cyc(0, 0, 0);
        chk("t3_release_pc", id_pc, 32'h10);
        chk("t3_release_valid", {31'b0, id_valid}, 32'd1);
        cyc(0, 0, 0);
        chk("t3_next_pc", id_pc, 32'h14);

        // T4: flush with 0x24 in flight
        repeat (3) cyc(0, 0, 0);
        chk("t4_pre_pc", id_pc, 32'h20);
        cyc(0, 1, 32'h200);
        chk("t4_flush_valid", {31'b0, id_valid}, 32'd0);
        stall = 1'b0; flush = 1'b0; #1;
        chk("t4_target_req", {31'b0, imem_req}, 32'd1);
        chk("t4_target_addr", imem_addr, 32'h200);
        cyc(0, 0, 0);
        chk("t4_gap_valid", {31'b0, id_valid}, 32'd0);
        cyc(0, 0, 0);
        chk("t4_target_pc", id_pc, 32'h200);
        chk("t4_target_valid", {31'b0, id_valid}, 32'd1);

        // T5: flush and stall together with the skid entry occupied
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 1, 32'h403);
        stall = 1'b0; flush = 1'b0; #1;
        chk("t5_target_addr", imem_addr, 32'h400);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t5_target_pc", id_pc, 32'h400);
        chk("t5_target_valid", {31'b0, id_valid}, 32'd1);

        // Random stall/flush traffic, with one mid-stream reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, $urandom);
        end
        stall = 1'b0; flush = 1'b0;

        // T6: address wrap and asynchronous reset on the second instance
        #1 rst2_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_req0", {31'b0, imem2_req}, 32'd1);
        chk("t6_addr0", imem2_addr, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        chk("t6_addr1", imem2_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("t6_addr2", imem2_addr, 32'h0000_0000);
        chk("t6_id_pc0", id2_pc, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        chk("t6_id_pc1", id2_pc, 32'hFFFF_FFFC);
        chk("t6_id_pc4_wrap", id2_pc_plus4, 32'h0);
        chk("t6_id_instr1", id2_instr, memf(32'hFFFF_FFFC));
        #2 rst2_n = 1'b0;
        #1;
        chk("t6_async_req",   {31'b0, imem2_req}, 32'd0);
        chk("t6_async_addr",  imem2_addr, 32'hFFFF_FFF8);
        chk("t6_async_instr", id2_instr, NOP);
        chk("t6_async_pc",    id2_pc, 32'h0);
        chk("t6_async_pc4",   id2_pc_plus4, 32'd4);
        chk("t6_async_valid", {31'b0, id2_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
